// File: rtl/io_inbuf_arbiter.sv
// Round-robin arbiter sharing the UART input buffer pop port among NREQ byte consumers.
// One byte per grant with a registered grant pulse; flush drains the buffer without delivery.
module io_inbuf_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [7:0]      rdata,
  input  logic            flush,
  output logic            busy,
  output logic [15:0]     pop_count,
  input  logic [7:0]      buf_data,
  input  logic            buf_empty,
  output logic            buf_pop
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            buf_pop_q, buf_pop_d;
  logic            busy_q, busy_d;
  logic [15:0]     pop_count_q, pop_count_d;
  logic [LW-1:0]   last_q, last_d;

  logic [LW-1:0]   win;
  logic            win_vld;
  logic [LW:0]     scan_idx;

  // Scan from farthest to nearest so the first requester after last overrides.
  always_comb begin
    win      = '0;
    win_vld  = 1'b0;
    scan_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      scan_idx = {1'b0, last_q} + (LW+1)'(k);
      if (scan_idx >= (LW+1)'(NREQ)) scan_idx = scan_idx - (LW+1)'(NREQ);
      if (req[scan_idx[LW-1:0]]) begin
        win     = scan_idx[LW-1:0];
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    rdata_d     = rdata_q;
    buf_pop_d   = 1'b0;
    pop_count_d = pop_count_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
        end else if (win_vld && !buf_empty) begin
          gnt_d[win]  = 1'b1;
          rdata_d     = buf_data;
          buf_pop_d   = 1'b1;
          pop_count_d = pop_count_q + 16'd1;
          last_d      = win;
          state_d     = SETTLE;
        end
      end
      SETTLE: state_d = IDLE;
      FLUSH: begin
        // Pop only on alternate cycles so buf_empty reflects the previous pop.
        if (!buf_pop_q) begin
          if (!buf_empty) begin
            buf_pop_d   = 1'b1;
            pop_count_d = pop_count_q + 16'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rdata_q     <= '0;
      buf_pop_q   <= 1'b0;
      busy_q      <= 1'b0;
      pop_count_q <= '0;
      last_q      <= LW'(NREQ - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rdata_q     <= rdata_d;
      buf_pop_q   <= buf_pop_d;
      busy_q      <= busy_d;
      pop_count_q <= pop_count_d;
      last_q      <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign rdata     = rdata_q;
  assign buf_pop   = buf_pop_q;
  assign busy      = busy_q;
  assign pop_count = pop_count_q;

endmodule

// File: tb/tb_io_inbuf_arbiter.sv
// Bench for io_inbuf_arbiter: queue-based buffer, behavioural arbiter model, directed and random phases.
module tb_io_inbuf_arbiter;

  localparam int NREQ = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] gnt;
  logic [7:0]      rdata;
  logic            flush = 1'b0;
  logic            busy;
  logic [15:0]     pop_count;
  logic [7:0]      buf_data = '0;
  logic            buf_empty = 1'b1;
  logic            buf_pop;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] bq[$];

  logic [NREQ-1:0] e_gnt;
  logic [7:0]      e_rdata;
  logic            e_pop;
  logic            e_busy;
  logic [15:0]     e_cnt;
  int              m_last;
  int              m_phase;  // 0 waiting, 1 just granted, 2 draining

  io_inbuf_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .rdata(rdata), .flush(flush),
    .busy(busy), .pop_count(pop_count), .buf_data(buf_data),
    .buf_empty(buf_empty), .buf_pop(buf_pop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    buf_empty = (bq.size() == 0);
    buf_data  = (bq.size() > 0) ? bq[0] : 8'h00;
  endtask

  task automatic model_reset();
    e_gnt = '0; e_rdata = '0; e_pop = 1'b0; e_busy = 1'b0; e_cnt = '0;
    m_last = NREQ - 1; m_phase = 0;
  endtask

  // Predicts the outputs after the coming rising edge from the current inputs and buffer.
  task automatic model_step();
    int w;
    if (rst) begin
      model_reset();
    end else if (m_phase == 0) begin
      e_gnt = '0; e_pop = 1'b0; e_busy = 1'b0;
      if (flush) begin
        m_phase = 2; e_busy = 1'b1;
      end else if (req != 0 && bq.size() > 0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
        e_gnt = NREQ'(1) << w;
        e_rdata = bq[0];
        e_pop = 1'b1;
        e_cnt = e_cnt + 16'd1;
        m_last = w;
        m_phase = 1;
        e_busy = 1'b1;
      end
    end else if (m_phase == 1) begin
      e_gnt = '0; e_pop = 1'b0; e_busy = 1'b0; m_phase = 0;
    end else begin
      e_gnt = '0;
      if (e_pop) e_pop = 1'b0;
      else if (bq.size() > 0) begin
        e_pop = 1'b1; e_cnt = e_cnt + 16'd1;
      end else begin
        m_phase = 0; e_busy = 1'b0;
      end
    end
  endtask

  // One clock: present inputs, let the edge happen, compare, let the buffer consume a pop.
  task automatic tick();
    refresh();
    model_step();
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("rdata", 32'(rdata), 32'(e_rdata));
    chk("buf_pop", 32'(buf_pop), 32'(e_pop));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("pop_count", 32'(pop_count), 32'(e_cnt));
    if (buf_pop && bq.size() > 0) void'(bq.pop_front());
    refresh();
  endtask

  initial begin
    int n_gnt, n_pop;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Round-robin with both requesters held.
    for (int i = 0; i < 4; i++) bq.push_back(8'h10 + 8'(i));
    req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 0) begin
        chk("rr_gnt", 32'(gnt), ((i / 2) % 2 == 0) ? 32'h1 : 32'h2);
        chk("rr_rdata", 32'(rdata), 32'h10 + 32'(i / 2));
      end else begin
        chk("rr_gap", 32'(gnt), 32'h0);
      end
    end
    req = '0;
    tick();
    chk("rr_count", 32'(pop_count), 32'd4);

    // Requests against an empty buffer.
    req = 2'b11;
    n_gnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt != 0 || buf_pop) n_gnt++;
    end
    chk("empty_no_activity", 32'(n_gnt), 32'd0);
    bq.push_back(8'h7E);
    tick();
    chk("empty_then_gnt", 32'(gnt), 32'h1);
    chk("empty_then_rdata", 32'(rdata), 32'h7E);
    req = '0;
    tick();
    tick();

    // Single requester.
    bq.push_back(8'h41);
    req = 2'b01;
    tick();
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_rdata", 32'(rdata), 32'h41);
    chk("single_pop", 32'(buf_pop), 32'h1);
    chk("single_count", 32'(pop_count), 32'd6);
    req = '0;
    tick();
    chk("single_pop_end", 32'(buf_pop), 32'h0);
    tick();

    // Flush beats a simultaneous request.
    for (int i = 0; i < 5; i++) bq.push_back(8'($urandom_range(0, 255)));
    flush = 1'b1;
    req = 2'b01;
    tick();
    chk("flush_busy", 32'(busy), 32'h1);
    flush = 1'b0;
    n_gnt = 0; n_pop = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (gnt != 0) n_gnt++;
      if (buf_pop) n_pop++;
    end
    chk("flush_pops", 32'(n_pop), 32'd5);
    chk("flush_no_gnt", 32'(n_gnt), 32'd0);
    chk("flush_rdata", 32'(rdata), 32'h41);
    chk("flush_count", 32'(pop_count), 32'd11);
    chk("flush_busy_end", 32'(busy), 32'h0);
    req = '0;
    tick();

    // Reset while settling after a grant.
    bq.push_back(8'hA1);
    bq.push_back(8'hA2);
    req = 2'b11;
    tick();
    rst = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_pop", 32'(buf_pop), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(pop_count), 32'h0);
    bq.delete();
    model_reset();
    tick();
    rst = 1'b0;
    bq.push_back(8'hB1);
    bq.push_back(8'hB2);
    req = 2'b11;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    chk("post_rst_rdata", 32'(rdata), 32'hB1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0 && bq.size() < 8) bq.push_back(8'($urandom_range(0, 255)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
